// File: rtl/sa_pkg.sv
// Shared element types and helpers for the systolic array input path.
// The element width and lane counts used by the stream gearbox are defined here.
package sa_pkg;

    localparam int unsigned DATA_WIDTH    = 9;
    localparam int unsigned IN_ELEM_WIDTH = 8;
    localparam int unsigned IN_LANES      = 16;
    localparam int unsigned OUT_LANES     = 14;

    typedef logic [DATA_WIDTH-1:0] elem_t;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } pack_state_t;

    // Widen one 8-bit operand to the array element width.
    function automatic elem_t extend_elem(input logic [IN_ELEM_WIDTH-1:0] b,
                                          input logic                     sign_ext);
        return {sign_ext & b[IN_ELEM_WIDTH-1], b};
    endfunction

endpackage

// File: rtl/elem_shift_buffer.sv
// Multi-pop / multi-push element FIFO kept in head-aligned order.
// Head window entries at or beyond the fill level read as zero.
module elem_shift_buffer
    import sa_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned PUSH_N = IN_LANES,
    parameter int unsigned WIN_N  = OUT_LANES,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        pop_n,
    input  logic                    push,
    input  elem_t [PUSH_N-1:0]      push_elems,
    output elem_t [WIN_N-1:0]       head,
    output logic [CNT_W-1:0]        count
);

    localparam int unsigned AW = $clog2(DEPTH);

    elem_t [DEPTH-1:0] mem_q;
    elem_t [DEPTH-1:0] mem_d;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  base;
    int unsigned       src;
    int unsigned       dst;

    // Pop shifts the survivors down first; pushed elements land right after them.
    always_comb begin
        mem_d = '0;
        src   = '0;
        dst   = '0;
        base  = count - pop_n;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            src = i + 32'(pop_n);
            if (src < DEPTH) begin
                mem_d[i] = mem_q[src[AW-1:0]];
            end
        end
        if (push) begin
            for (int unsigned k = 0; k < PUSH_N; k++) begin
                dst = 32'(base) + k;
                if (dst < DEPTH) begin
                    mem_d[dst[AW-1:0]] = push_elems[k];
                end
            end
        end
        count_d = count - pop_n + (push ? CNT_W'(PUSH_N) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head = '0;
        for (int unsigned j = 0; j < WIN_N; j++) begin
            head[j] = (CNT_W'(j) < count) ? mem_q[j] : '0;
        end
    end

endmodule

// File: rtl/axis_int8_to_9bit_packer.sv
// Gearbox from 16 x int8 AXI-Stream beats to 14 x 9-bit array beats.
// Tiles are flushed on tlast with the final beat zero-padded.
module axis_int8_to_9bit_packer #(
    parameter int unsigned IN_WIDTH      = 128,
    parameter int unsigned IN_ELEM_WIDTH = 8,
    parameter int unsigned OUT_WIDTH     = 128,
    parameter int unsigned DATA_WIDTH    = 9,
    parameter int unsigned SIGNED        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready
);

    localparam int unsigned IN_LANES  = IN_WIDTH / IN_ELEM_WIDTH;
    localparam int unsigned OUT_LANES = OUT_WIDTH / DATA_WIDTH;
    localparam int unsigned BUF_DEPTH = 32;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PAD_W     = OUT_WIDTH - OUT_LANES * DATA_WIDTH;

    sa_pkg::pack_state_t              state_q;
    sa_pkg::pack_state_t              state_d;
    sa_pkg::elem_t [IN_LANES-1:0]     in_elems;
    sa_pkg::elem_t [OUT_LANES-1:0]    head;
    logic [CNT_W-1:0]                 count;
    logic [CNT_W-1:0]                 pop_n;
    logic                             draining;
    logic                             in_ready;
    logic                             out_valid;
    logic                             out_last;
    logic                             push;
    logic                             pop;

    always_comb begin
        in_elems = '0;
        for (int unsigned i = 0; i < IN_LANES; i++) begin
            in_elems[i] = sa_pkg::extend_elem(s_axis_tdata[i*IN_ELEM_WIDTH +: IN_ELEM_WIDTH],
                                              SIGNED != 0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= sa_pkg::ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready/valid come from registered count and state only; rst just forces them low.
    always_comb begin
        state_d   = state_q;
        draining  = (state_q == sa_pkg::ST_DRAIN);
        in_ready  = !draining && (count <= CNT_W'(BUF_DEPTH - IN_LANES));
        out_valid = (count >= CNT_W'(OUT_LANES)) || (draining && (count != '0));
        out_last  = draining && (count <= CNT_W'(OUT_LANES));
        push      = s_axis_tvalid && in_ready && !rst;
        pop       = out_valid && m_axis_tready && !rst;
        pop_n     = '0;
        if (pop) begin
            pop_n = (count < CNT_W'(OUT_LANES)) ? count : CNT_W'(OUT_LANES);
        end
        unique case (state_q)
            sa_pkg::ST_FILL:  if (push && s_axis_tlast) state_d = sa_pkg::ST_DRAIN;
            sa_pkg::ST_DRAIN: if (pop && out_last)      state_d = sa_pkg::ST_FILL;
            default:          state_d = sa_pkg::ST_FILL;
        endcase
    end

    elem_shift_buffer #(
        .DEPTH  (BUF_DEPTH),
        .PUSH_N (IN_LANES),
        .WIN_N  (OUT_LANES),
        .CNT_W  (CNT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .pop_n      (pop_n),
        .push       (push),
        .push_elems (in_elems),
        .head       (head),
        .count      (count)
    );

    assign s_axis_tready = in_ready && !rst;
    assign m_axis_tvalid = out_valid && !rst;
    assign m_axis_tlast  = out_last && !rst;
    assign m_axis_tdata  = rst ? '0 : {{PAD_W{1'b0}}, head};

endmodule

// File: tb/tb_axis_int8_to_9bit_packer.sv
// Self-checking bench for the int8 -> 9-bit stream gearbox.
// Signed and unsigned instances share stimulus; a byte scoreboard checks every output beat.
module tb_axis_int8_to_9bit_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready, u_s_tready;
    logic [127:0] m_tdata, u_m_tdata;
    logic         m_tvalid, u_m_tvalid;
    logic         m_tlast, u_m_tlast;
    logic         m_tready = 1'b0;

    always #5 clk = ~clk;

    axis_int8_to_9bit_packer #(
        .IN_WIDTH(128), .IN_ELEM_WIDTH(8), .OUT_WIDTH(128), .DATA_WIDTH(9), .SIGNED(1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready)
    );

    axis_int8_to_9bit_packer #(
        .IN_WIDTH(128), .IN_ELEM_WIDTH(8), .OUT_WIDTH(128), .DATA_WIDTH(9), .SIGNED(0)
    ) dut_u (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(u_s_tready),
        .m_axis_tdata(u_m_tdata), .m_axis_tvalid(u_m_tvalid), .m_axis_tlast(u_m_tlast),
        .m_axis_tready(m_tready)
    );

    typedef struct {
        logic [7:0] b;
        logic       last;
    } ent_t;

    ent_t         sb[$];
    int           tile_beats_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    bit           mon_en = 0;
    bit           mdl_drain = 0;
    bit           rand_ready = 0;
    int           cur_tile_beats = 0;
    bit           stall_prev = 0;
    logic [127:0] prev_data;
    logic         prev_last;
    logic [127:0] exp_s, exp_u;
    logic         exp_last, exp_ready, exp_valid;
    ent_t         e;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_tready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor: state seen at a negedge is the DUT state of the current cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last)
                    $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
                else n_pass++;
            end
            exp_ready = !mdl_drain && (sb.size() <= 16);
            exp_valid = (sb.size() >= 14) || (mdl_drain && sb.size() != 0);
            n_checks++;
            if (s_tready !== exp_ready || u_s_tready !== exp_ready ||
                m_tvalid !== exp_valid || u_m_tvalid !== exp_valid)
                $display("FAIL handshake: s_ready=%b/%b m_valid=%b/%b required s_ready=%b m_valid=%b (count=%0d drain=%0d)",
                         s_tready, u_s_tready, m_tvalid, u_m_tvalid, exp_ready, exp_valid,
                         sb.size(), mdl_drain);
            else n_pass++;
            if (m_tvalid && m_tready) begin
                exp_s = '0;
                exp_u = '0;
                exp_last = 1'b0;
                for (int j = 0; j < 14; j++) begin
                    if (!exp_last && sb.size() != 0) begin
                        e = sb.pop_front();
                        exp_s[9*j +: 9] = {e.b[7], e.b};
                        exp_u[9*j +: 9] = {1'b0, e.b};
                        exp_last = e.last;
                    end
                end
                n_checks++;
                if (m_tdata !== exp_s || u_m_tdata !== exp_u || m_tlast !== exp_last || u_m_tlast !== exp_last)
                    $display("FAIL out_beat: data=%h udata=%h last=%b/%b required data=%h udata=%h last=%b",
                             m_tdata, u_m_tdata, m_tlast, u_m_tlast, exp_s, exp_u, exp_last);
                else n_pass++;
                if (exp_last) begin
                    mdl_drain = 0;
                    tile_beats_q.push_back(cur_tile_beats + 1);
                    cur_tile_beats = 0;
                end else begin
                    cur_tile_beats++;
                end
            end
            if (s_tvalid && s_tready) begin
                n_checks++;
                if (mdl_drain) $display("FAIL accept_in_drain: accepted=1 required=0");
                else n_pass++;
                for (int i = 0; i < 16; i++)
                    sb.push_back('{b: s_tdata[8*i +: 8], last: (s_tlast && i == 15)});
                if (s_tlast) mdl_drain = 1;
            end
        end
        stall_prev = mon_en && m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
    end

    task automatic send_beat(input logic [127:0] d, input logic l, input int unsigned gap);
        bit ok = 0;
        s_tvalid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_tdata = d;
        s_tlast = l;
        s_tvalid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (s_tready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: accepted=0 required=1");
        end
    endtask

    task automatic wait_tiles(input int n);
        bit ok = 0;
        for (int t = 0; t < 4000; t++) begin
            @(posedge clk); #1;
            if (tile_beats_q.size() >= n) begin ok = 1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL tile_timeout: tiles=%0d required=%0d", tile_beats_q.size(), n);
        else n_pass++;
    endtask

    task automatic check_tile(input int exp_beats, input string name);
        int got = -1;
        if (tile_beats_q.size() != 0) got = tile_beats_q.pop_front();
        n_checks++;
        if (got != exp_beats) $display("FAIL %s: beats=%0d required=%0d", name, got, exp_beats);
        else n_pass++;
    endtask

    function automatic logic [127:0] ramp(input int base);
        logic [127:0] d = '0;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(base + i);
        return d;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || s_tready !== 1'b0 ||
            u_m_tvalid !== 1'b0 || u_s_tready !== 1'b0)
            $display("FAIL reset_outputs: valid=%b last=%b data=%h s_ready=%b required 0 0 0 0",
                     m_tvalid, m_tlast, m_tdata, s_tready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0)
            $display("FAIL reset_release: s_ready=%b valid=%b required s_ready=1 valid=0", s_tready, m_tvalid);
        else n_pass++;
        @(posedge clk); #1;
        mon_en = 1;
        m_tready = 1'b1;
    endtask

    task automatic test_single_beat();
        send_beat(ramp(0), 1'b1, 0);
        wait_tiles(1);
        check_tile(2, "single_beat_count");
    endtask

    task automatic test_seven_beat();
        for (int b = 0; b < 7; b++) send_beat(ramp(16 * b), b == 6, 0);
        wait_tiles(1);
        check_tile(8, "seven_beat_count");
    endtask

    task automatic test_sign_ext();
        logic [127:0] d = '0;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = (i % 2 == 0) ? 8'h80 : 8'hFF;
        send_beat(d, 1'b1, 0);
        @(negedge clk);
        n_checks++;
        if (m_tdata[8:0] !== 9'h180 || m_tdata[17:9] !== 9'h1FF)
            $display("FAIL sign_signed: lane0=%h lane1=%h required 180 1ff", m_tdata[8:0], m_tdata[17:9]);
        else n_pass++;
        n_checks++;
        if (u_m_tdata[8:0] !== 9'h080 || u_m_tdata[17:9] !== 9'h0FF)
            $display("FAIL sign_unsigned: lane0=%h lane1=%h required 080 0ff", u_m_tdata[8:0], u_m_tdata[17:9]);
        else n_pass++;
        wait_tiles(1);
        check_tile(2, "sign_tile_count");
    endtask

    task automatic test_random();
        logic [127:0] d;
        rand_ready = 1;
        for (int b = 0; b < 20; b++) begin
            for (int w = 0; w < 4; w++) d[32*w +: 32] = $urandom;
            send_beat(d, b == 19, $urandom_range(0, 2));
        end
        wait_tiles(1);
        rand_ready = 0;
        m_tready = 1'b1;
        check_tile(23, "random_tile_count");
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) send_beat(ramp(100 + 16 * b), b == 2, 0);
        send_beat(ramp(200), 1'b1, 0);
        wait_tiles(2);
        check_tile(4, "b2b_first_count");
        check_tile(2, "b2b_second_count");
    endtask

    task automatic test_reset_mid_drain();
        bit ok = 0;
        for (int b = 0; b < 6; b++) send_beat(ramp(16 * b), b == 5, 0);
        for (int t = 0; t < 200; t++) begin
            if (mdl_drain && sb.size() == 12) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        m_tready = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL drain12_reach: reached=0 required=1");
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tlast !== 1'b1)
            $display("FAIL drain12_state: valid=%b last=%b required 1 1", m_tvalid, m_tlast);
        else n_pass++;
        @(posedge clk); #1;
        mon_en = 0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0)
            $display("FAIL midrst_assert: valid=%b s_ready=%b required 0 0", m_tvalid, s_tready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        tile_beats_q.delete();
        mdl_drain = 0;
        cur_tile_beats = 0;
        @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0)
            $display("FAIL midrst_release: s_ready=%b valid=%b required 1 0", s_tready, m_tvalid);
        else n_pass++;
        @(posedge clk); #1;
        mon_en = 1;
        m_tready = 1'b1;
        send_beat(ramp(0), 1'b1, 0);
        wait_tiles(1);
        check_tile(2, "post_reset_count");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: finished=0 required=1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_seven_beat();
        test_sign_ext();
        test_random();
        test_back_to_back();
        test_reset_mid_drain();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_int8_to_9bit_packer.md
# axis_int8_to_9bit_packer

Upstream gearbox for the systolic array input stream. It accepts 128-bit AXI-Stream beats carrying 16 packed 8-bit operands from the read FIFO, sign-extends each operand to the array's 9-bit element width, and repacks the elements into 128-bit beats of 14 lanes. The output feeds the systolic array slave port directly. The block stalls input as needed, because 16 elements arrive per input beat but only 14 leave per output beat. On `tlast` it flushes, zero-padding the final beat.

## Interface
Parameters:
- `IN_WIDTH`, 128, input tdata width.
- `IN_ELEM_WIDTH`, 8, width of one input element.
- `OUT_WIDTH`, 128, output tdata width.
- `DATA_WIDTH`, 9, array element width.
- `SIGNED`, 1, 1 = sign-extend, 0 = zero-extend.
- Derived: `IN_LANES = IN_WIDTH/IN_ELEM_WIDTH` (16), `OUT_LANES = OUT_WIDTH/DATA_WIDTH` (14), `BUF_DEPTH` (32, power of two, at least `IN_LANES + OUT_LANES - 1`).

Ports:
- `clk`  in  1  single clock. All state is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  `IN_WIDTH`  element i is at bits [8i+7:8i].
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tlast`  in  1  last beat of the tile.
- `s_axis_tready`  out  1  input accept.
- `m_axis_tdata`  out  `OUT_WIDTH`  lane j is at bits [9j+8:9j]. Bits [127:126] are always 0.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tlast`  out  1  final beat of the tile.
- `m_axis_tready`  in  1  downstream accept.

## Operation
- Element buffer: `BUF_DEPTH` x `DATA_WIDTH` registers, in FIFO order, plus `count` (0..`BUF_DEPTH`) and a `draining` flag.
- State machine:
  - FILL (`draining`=0):
    - `s_axis_tready = (count <= BUF_DEPTH-IN_LANES)`.
    - Accepting a beat appends 16 extended elements, in order of element 0 to 15.
    - Accepting a beat with `tlast` sets state to DRAIN.
  - DRAIN (`draining`=1):
    - `s_axis_tready = 0`.
    - Leaves DRAIN when the beat with `tlast` is consumed. `count` is then 0.
- Output valid:
  - `m_axis_tvalid = (count >= OUT_LANES) | (draining & count != 0)`.
  - Lanes 0..13 are buffer entries 0..13.
  - Lanes at or above `count` output 0. This applies only in DRAIN.
- `m_axis_tlast = draining & (count <= OUT_LANES)`.
- On an output handshake, remove `min(count, OUT_LANES)` entries from the head.
- Simultaneous input and output handshake in the same cycle:
  - Remove first, then append.
  - `count_next = count - min(count,14) + 16`.
  - Element order is preserved.
- Elements are never dropped or duplicated. A tile of N input beats yields `ceil(16N/14)` output beats.
- `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` are held stable while `tvalid & !tready`. No input accept may change the head 14 entries while they are being presented.
- Extension:
  - `SIGNED`=1: element = {b[7], b}.
  - `SIGNED`=0: element = {1'b0, b}.
- Reset, including mid-tile or mid-drain:
  - `count` = 0, `draining` = 0, buffer contents don't-care.
  - Outputs: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `s_axis_tready`=0 during reset and 1 in the first cycle after it.

## Timing
- Latency: an input beat accepted at edge N can appear on the output in the cycle after edge N (registered buffer, combinational output select). There are no other pipeline stages.
- `s_axis_tready` and `m_axis_tvalid` depend only on registered state. There is no combinational path from `m_axis_tready` to `s_axis_tready`.
- Steady state with `m_axis_tready`=1: input accepts 7 of every 8 cycles, and the output is valid every cycle once `count >= 14`.
- A new tile's first beat is accepted in the cycle after the previous tile's `tlast` output handshake.

## Structure
- Shared package `sa_pkg` holds:
  - `DATA_WIDTH`, `IN_LANES`, `OUT_LANES`;
  - typedef `elem_t` (logic [DATA_WIDTH-1:0]);
  - function `extend_elem`.
- One sub-module, `elem_shift_buffer`: a parameterised multi-pop/multi-push element FIFO providing head-window read, `count` and flush-safe zero masking. The top level contains the DRAIN flag, the handshake logic and the tlast logic.

## Test plan
- Single-beat tile with bytes 0x00..0x0F and `tlast`: expect output beat 1 with lanes 0..13 = 0..13 and `tlast`=0, then beat 2 with lanes 0,1 = 14,15, lanes 2..13 = 0, and `tlast`=1.
- Seven-beat tile of bytes 0..111 with `tlast` on beat 7: expect exactly 8 output beats, lane values 0..111 in order, no padding, `tlast` only on beat 8.
- Sign extension with bytes 0x80 and 0xFF, `SIGNED`=1: expect lanes 0x180 and 0x1FF. With `SIGNED`=0: expect 0x080 and 0x0FF.
- Random `m_axis_tready` (50%) and random `s_axis_tvalid` over a 20-beat tile: the scoreboard matches the element sequence, output is stable under stall, `s_axis_tready` never rises while `count > 16`, and no input is accepted in DRAIN.
- Back-to-back tiles (3 beats, then 1 beat): expect 4 output beats for the first tile with `tlast` on beat 4, then 2 for the second. No elements mix across the tile boundary.
- Assert `rst` for 1 cycle mid-DRAIN with `count`=12: expect `m_axis_tvalid`=0 immediately, `s_axis_tready`=1 on the next cycle, and a following 1-beat tile emitted as in the first scenario.
